sn_dot_accum: RTL
=================

// Module: sn_dot_accum
// PURPOSE
// - Downstream consumer of the SNG stochastic bit streams. It sequences N_TERMS stochastic multiplies
//   (bitwise AND of an activation stream and a weight stream), counts the ones over each STREAM_LEN
//   window, and accumulates signed counts into a binary dot-product result.
// - Drives the start/stop inputs of the upstream SNG pair and hands the result to the next NN stage
//   through a valid/ready handshake.
// PARAMETERS
// - N_TERMS     9   products per dot product (3x3 kernel)
// - STREAM_LEN  16  bits per stochastic stream; fixed by the 4-bit SNG
// - SNG_LAT     2   cycles from o_start_sng high to the first valid stream bit
// - CNT_W       5   $clog2(STREAM_LEN+1): per-term count width, range 0..16
// - ACC_W       10  CNT_W+$clog2(N_TERMS)+1: signed accumulator width
// PORTS
// - i_clk_sng    in   1      clock, rising edge
// - i_rst_sng    in   1      reset, asynchronous, active-high
// - i_start      in   1      request a new dot product; honoured only in IDLE, or in DONE in the handshake cycle
// - i_abort      in   1      cancel the run in progress
// - i_sn_x       in   1      activation stochastic bit (from SNG o_sn_bit)
// - i_sn_w       in   1      weight stochastic bit (from SNG o_sn_bit)
// - i_sign       in   1      weight sign of the current term; 1 = subtract; sampled in LAUNCH
// - o_start_sng  out  1      one-cycle pulse to the SNG i_start_sng of both generators
// - o_stop_sng   out  1      one-cycle pulse to the SNG i_stop_sng, on abort only
// - o_term_idx   out  4      index of the current term, 0..N_TERMS-1; selects the upstream operands
// - o_busy       out  1      high in every state except IDLE
// - o_result     out  ACC_W  signed dot-product result
// - o_valid      out  1      result valid; held until accepted
// - i_ready      in   1      downstream accept
// BEHAVIOUR
// - Reset: state IDLE; o_result, o_valid, o_busy, o_start_sng, o_stop_sng and o_term_idx are all 0;
//   the accumulator and count are cleared.
// - States: IDLE, LAUNCH, WAIT, COUNT, ACCUM, DONE. All outputs are registered.
// - IDLE -> LAUNCH when i_start is high. Entering LAUNCH clears the accumulator and sets term_idx to 0.
// - LAUNCH (1 cycle): o_start_sng=1, i_sign is captured, count is cleared. Next state is WAIT.
// - WAIT (SNG_LAT cycles): no sampling. Next state is COUNT.
// - COUNT (STREAM_LEN cycles): count += (i_sn_x & i_sn_w). Next state is ACCUM.
// - ACCUM (1 cycle): acc = acc +/- zero-extended count, according to the captured sign.
//   If term_idx == N_TERMS-1 the next state is DONE; otherwise term_idx++ and the next state is LAUNCH.
// - Per-term cost is STREAM_LEN+SNG_LAT+2 = 20 cycles.
// - DONE: o_result = acc and o_valid = 1; both stay stable while i_ready = 0.
//   If i_ready = 1, o_valid drops the next cycle. If i_start is also high in that cycle the next state
//   is LAUNCH; otherwise it is IDLE.
// - Latency: i_start sampled at edge 0 -> o_valid first high in cycle N_TERMS*20+1 = 181 (default parameters).
// - i_start is ignored in LAUNCH, WAIT, COUNT and ACCUM, and in DONE without i_ready.
// - i_abort in any of LAUNCH, WAIT, COUNT, ACCUM or DONE:
//   - o_stop_sng is high for one cycle, the next state is IDLE, and o_valid is 0 next cycle.
//   - The accumulator is discarded.
//   - i_abort has priority over i_start and i_ready. It has no effect in IDLE.
// - Arithmetic: count saturates naturally at 16 (no overflow possible). ACC_W guarantees no
//   accumulator overflow: range is -144..+144.
// - An asynchronous reset mid-operation returns to the reset values immediately, without an
//   o_stop_sng pulse; the SNGs share the same reset.
// STRUCTURE
// - Shared package sn_pkg:
//   - state enum sn_dot_state_t;
//   - constants SN_STREAM_LEN=16 and SN_SNG_LAT=2;
//   - function clog2 helper for CNT_W and ACC_W.
// - One sub-module, sn_popcount_window (ports: clear, enable, bit, count[CNT_W]).
//   The parent holds the FSM, term index, sign register, accumulator and handshake.
// TESTING
// - All-ones: i_sn_x = i_sn_w = 1 for all cycles, i_sign = 0 -> o_result = 144, o_valid rises in cycle 181,
//   o_start_sng pulses in cycles 1, 21, ..., 161.
// - Alternating signs: x = 1, w = 1010... (count 8 per term), i_sign = 0,1,0,...,0 -> o_result = +8;
//   with all i_sign = 1 -> o_result = -72 (10'h3B8).
// - Zero operand: i_sn_x = 0 throughout -> o_result = 0, o_valid asserted, handshake completes.
// - Backpressure: i_ready = 0 for 10 cycles in DONE while pulsing i_start -> o_result and o_valid stable,
//   no o_start_sng; then i_ready = 1 together with i_start = 1 -> LAUNCH next cycle.
// - Abort: i_abort during COUNT of term 3 -> one-cycle o_stop_sng, o_busy = 0 next cycle, no o_valid;
//   a following all-ones run still gives 144.
// - Reset: assert i_rst_sng mid-COUNT -> all outputs 0 immediately, IDLE;
//   after release, i_start yields a correct run.

Source files
------------

// File: rtl/sn_pkg.sv
// Shared definitions for the stochastic dot-product datapath.
package sn_pkg;

  localparam int unsigned SN_STREAM_LEN = 16;
  localparam int unsigned SN_SNG_LAT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_COUNT,
    ST_ACCUM,
    ST_DONE
  } sn_dot_state_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sn_popcount_window.sv
// Counts ones of a stochastic product stream over one window.
module sn_popcount_window
  import sn_pkg::*;
#(
  parameter int unsigned CNT_W = clog2(SN_STREAM_LEN + 1)
) (
  input  logic             i_clk_sng,
  input  logic             i_rst_sng,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_bit,
  output logic [CNT_W-1:0] count
);

  // Window counter: clear wins over counting.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && data_bit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sn_dot_accum.sv
// Sequences stochastic multiplies, accumulates signed per-term counts
// into a binary dot product and hands it off via valid/ready.
module sn_dot_accum
  import sn_pkg::*;
#(
  parameter int unsigned N_TERMS    = 9,
  parameter int unsigned STREAM_LEN = SN_STREAM_LEN,
  parameter int unsigned SNG_LAT    = SN_SNG_LAT,
  parameter int unsigned CNT_W      = clog2(STREAM_LEN + 1),
  parameter int unsigned ACC_W      = CNT_W + clog2(N_TERMS) + 1
) (
  input  logic                    i_clk_sng,
  input  logic                    i_rst_sng,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_sn_x,
  input  logic                    i_sn_w,
  input  logic                    i_sign,
  output logic                    o_start_sng,
  output logic                    o_stop_sng,
  output logic [3:0]              o_term_idx,
  output logic                    o_busy,
  output logic signed [ACC_W-1:0] o_result,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int unsigned PH_MAX = (STREAM_LEN > SNG_LAT) ? STREAM_LEN : SNG_LAT;
  localparam int unsigned PH_W   = clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] WAIT_LAST  = PH_W'(SNG_LAT - 1);
  localparam logic [PH_W-1:0] COUNT_LAST = PH_W'(STREAM_LEN - 1);
  localparam logic [3:0]      LAST_TERM  = 4'(N_TERMS - 1);

  sn_dot_state_t    state;
  logic [PH_W-1:0]  phase;
  logic             sign_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic             cnt_en;
  logic             prod_bit;

  assign cnt_clear = (state == ST_LAUNCH);
  assign cnt_en    = (state == ST_COUNT);
  assign prod_bit  = i_sn_x & i_sn_w;

  sn_popcount_window #(
    .CNT_W(CNT_W)
  ) u_popcount (
    .i_clk_sng(i_clk_sng),
    .i_rst_sng(i_rst_sng),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .data_bit (prod_bit),
    .count    (cnt)
  );

  // Signed accumulate of the zero-extended window count.
  always_comb begin
    acc_next = acc + ACC_W'(cnt);
    if (sign_q) begin
      acc_next = acc - ACC_W'(cnt);
    end
  end

  // Control FSM; every output is registered from the next-state decision.
  always_ff @(posedge i_clk_sng or posedge i_rst_sng) begin
    if (i_rst_sng) begin
      state       <= ST_IDLE;
      phase       <= '0;
      sign_q      <= 1'b0;
      acc         <= '0;
      o_term_idx  <= '0;
      o_start_sng <= 1'b0;
      o_stop_sng  <= 1'b0;
      o_busy      <= 1'b0;
      o_result    <= '0;
      o_valid     <= 1'b0;
    end else begin
      o_start_sng <= 1'b0;
      o_stop_sng  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state       <= ST_LAUNCH;
            acc         <= '0;
            o_term_idx  <= '0;
            o_start_sng <= 1'b1;
            o_busy      <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          sign_q <= i_sign;
          phase  <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (phase == WAIT_LAST) begin
            phase <= '0;
            state <= ST_COUNT;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ST_COUNT: begin
          if (phase == COUNT_LAST) begin
            phase <= '0;
            state <= ST_ACCUM;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        ST_ACCUM: begin
          acc <= acc_next;
          if (o_term_idx == LAST_TERM) begin
            state    <= ST_DONE;
            o_result <= acc_next;
            o_valid  <= 1'b1;
          end else begin
            o_term_idx  <= o_term_idx + 4'd1;
            state       <= ST_LAUNCH;
            o_start_sng <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (i_start) begin
              state       <= ST_LAUNCH;
              acc         <= '0;
              o_term_idx  <= '0;
              o_start_sng <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      // Abort overrides whatever the case above decided.
      if (i_abort && (state != ST_IDLE)) begin
        state       <= ST_IDLE;
        acc         <= '0;
        o_term_idx  <= '0;
        o_start_sng <= 1'b0;
        o_stop_sng  <= 1'b1;
        o_busy      <= 1'b0;
        o_valid     <= 1'b0;
      end
    end
  end

endmodule
